pwm_duty_decoder: RTL

- Reads back the four H-bridge PWM lines produced by motor_cntrl (fwd_rht, rev_rht, fwd_lft, rev_lft).
- Reconstructs the signed 11-bit drive command per side by measuring high-time over one PWM period.
- Used as a closed-loop monitor in system benches and as an on-chip drive sanity checker that flags shoot-through (fwd and rev both high).

---
 rtl/pwm_dec_pkg.sv | 27 ++
 rtl/pwm_chan_meas.sv | 80 ++++++++
 rtl/pwm_duty_decoder.sv | 99 +++++++++
 3 files changed

// File: rtl/pwm_dec_pkg.sv
// Shared defaults, limits and side-status encoding for the PWM duty decoder.
package pwm_dec_pkg;

    localparam int unsigned DEF_PERIOD_W = 10;
    localparam int unsigned DEF_MEAS_W   = 11;
    localparam int unsigned MEAS_MAX     = (1 << (DEF_MEAS_W - 1)) - 1;

    typedef enum logic [1:0] {
        DRV_FWD      = 2'd0,
        DRV_REV      = 2'd1,
        DRV_OFF      = 2'd2,
        DRV_CONFLICT = 2'd3
    } drv_stat_e;

    // Classify one side's window from "any forward" / "any reverse" activity.
    function automatic drv_stat_e drv_status(input logic f_act, input logic r_act);
        drv_stat_e st;
        case ({f_act, r_act})
            2'b10:   st = DRV_FWD;
            2'b01:   st = DRV_REV;
            2'b11:   st = DRV_CONFLICT;
            default: st = DRV_OFF;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/pwm_chan_meas.sv
// One H-bridge side: forward/reverse high-time counters, sticky shoot-through
// flag and the signed duty value formed at window end.
module pwm_chan_meas
    import pwm_dec_pkg::*;
#(
    parameter int unsigned PERIOD_W = DEF_PERIOD_W,
    parameter int unsigned MEAS_W   = DEF_MEAS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fwd,
    input  logic              rev,
    input  logic              win_end,
    input  logic              clr_fault,
    output logic [MEAS_W-1:0] meas_c,
    output logic              conflict_c,
    output logic              shoot
);

    localparam int unsigned       CNT_W   = PERIOD_W + 1;
    localparam logic [CNT_W-1:0]  CNT_SAT = {1'b1, {PERIOD_W{1'b0}}};
    localparam logic [MEAS_W-1:0] MAG_MAX = {1'b0, {(MEAS_W-1){1'b1}}};

    logic [CNT_W-1:0]  fwd_cnt, rev_cnt;
    logic [CNT_W-1:0]  fwd_nxt_c, rev_nxt_c;
    logic [MEAS_W-1:0] fwd_ext_c, rev_ext_c;
    logic [MEAS_W-1:0] fwd_mag_c, rev_mag_c;
    drv_stat_e         stat_c;

    // Saturating increments; these include the current cycle's sample so the
    // window-end evaluation sees every cycle of the window.
    always_comb begin
        fwd_nxt_c = fwd_cnt;
        rev_nxt_c = rev_cnt;
        if (fwd && (fwd_cnt != CNT_SAT)) fwd_nxt_c = fwd_cnt + CNT_W'(1);
        if (rev && (rev_cnt != CNT_SAT)) rev_nxt_c = rev_cnt + CNT_W'(1);
    end

    // Counters restart on the window-end edge so no sample is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt <= '0;
            rev_cnt <= '0;
        end else if (win_end) begin
            fwd_cnt <= '0;
            rev_cnt <= '0;
        end else begin
            fwd_cnt <= fwd_nxt_c;
            rev_cnt <= rev_nxt_c;
        end
    end

    // Clamp magnitudes so a full-window high reads as the largest positive value.
    always_comb begin
        fwd_ext_c = MEAS_W'(fwd_nxt_c);
        rev_ext_c = MEAS_W'(rev_nxt_c);
        fwd_mag_c = (fwd_ext_c > MAG_MAX) ? MAG_MAX : fwd_ext_c;
        rev_mag_c = (rev_ext_c > MAG_MAX) ? MAG_MAX : rev_ext_c;
    end

    // Signed result: forward positive, reverse negative, conflicting reads zero.
    always_comb begin
        meas_c     = '0;
        conflict_c = 1'b0;
        stat_c     = drv_status(|fwd_nxt_c, |rev_nxt_c);
        case (stat_c)
            DRV_FWD:      meas_c = fwd_mag_c;
            DRV_REV:      meas_c = -rev_mag_c;
            DRV_CONFLICT: conflict_c = 1'b1;
            default:      meas_c = '0;
        endcase
    end

    // Sticky shoot-through flag; a new coincidence beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shoot <= 1'b0;
        else        shoot <= (fwd & rev) | (shoot & ~clr_fault);
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: rebuilds the signed per-side drive command from the four
// H-bridge lines over a free-running 2^PERIOD_W clock window.
// Optional macro PWM_DEC_SYNC_EN adds a 2-flop synchronizer on each PWM input.
module pwm_duty_decoder
    import pwm_dec_pkg::*;
#(
    parameter int unsigned PERIOD_W = DEF_PERIOD_W,
    parameter int unsigned MEAS_W   = DEF_MEAS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fwd_rht,
    input  logic              rev_rht,
    input  logic              fwd_lft,
    input  logic              rev_lft,
    input  logic              clr_fault,
    output logic [MEAS_W-1:0] rht_meas,
    output logic [MEAS_W-1:0] lft_meas,
    output logic              meas_vld,
    output logic              shoot_rht,
    output logic              shoot_lft,
    output logic              dir_err
);

    logic [PERIOD_W-1:0] win_cnt;
    logic                win_end_c;
    logic                fr_s, rr_s, fl_s, rl_s;
    logic [MEAS_W-1:0]   rht_meas_c, lft_meas_c;
    logic                rht_conf_c, lft_conf_c;

`ifdef PWM_DEC_SYNC_EN
    logic [3:0] sync_q1, sync_q2;

    // Two-stage synchronizer for drivers outside this clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {fwd_rht, rev_rht, fwd_lft, rev_lft};
            sync_q2 <= sync_q1;
        end
    end

    assign {fr_s, rr_s, fl_s, rl_s} = sync_q2;
`else
    assign {fr_s, rr_s, fl_s, rl_s} = {fwd_rht, rev_rht, fwd_lft, rev_lft};
`endif

    // Free-running window counter; window closes when it reads all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_cnt <= '0;
        else        win_cnt <= win_cnt + PERIOD_W'(1);
    end

    assign win_end_c = &win_cnt;

    pwm_chan_meas #(.PERIOD_W(PERIOD_W), .MEAS_W(MEAS_W)) u_rht (
        .clk        (clk),
        .rst_n      (rst_n),
        .fwd        (fr_s),
        .rev        (rr_s),
        .win_end    (win_end_c),
        .clr_fault  (clr_fault),
        .meas_c     (rht_meas_c),
        .conflict_c (rht_conf_c),
        .shoot      (shoot_rht)
    );

    pwm_chan_meas #(.PERIOD_W(PERIOD_W), .MEAS_W(MEAS_W)) u_lft (
        .clk        (clk),
        .rst_n      (rst_n),
        .fwd        (fl_s),
        .rev        (rl_s),
        .win_end    (win_end_c),
        .clr_fault  (clr_fault),
        .meas_c     (lft_meas_c),
        .conflict_c (lft_conf_c),
        .shoot      (shoot_lft)
    );

    // Capture both sides' results and the strobe on the window-end edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rht_meas <= '0;
            lft_meas <= '0;
            dir_err  <= 1'b0;
            meas_vld <= 1'b0;
        end else begin
            meas_vld <= win_end_c;
            if (win_end_c) begin
                rht_meas <= rht_meas_c;
                lft_meas <= lft_meas_c;
                dir_err  <= rht_conf_c | lft_conf_c;
            end
        end
    end

endmodule
